// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   uart_state_e   : frame FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   OVERSAMPLE_DEF : default number of baud ticks per bit period
//   MID_TICK       : tick count at which the middle of the start bit is reached
//   clog2()        : constant-friendly ceil(log2) used to size counters
//   mid_tick()     : MID_TICK for an arbitrary oversampling factor
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_TICK       = OVERSAMPLE_DEF / 2 - 1;

  // Smallest r with 2**r >= value; stops at 30 so the shift never overflows.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int mid_tick(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundle of the receiver's serial input, baud tick and parallel result.
//   i_rate       : one-cycle pulse at OVERSAMPLE x baud
//   i_rx         : serial line, idles high
//   o_data       : last received word
//   o_rx_done    : one-cycle frame-complete strobe
//   o_frame_err  : stop bit sampled low, coincident with o_rx_done
//   o_parity_err : parity mismatch (only when UART_RX_PARITY_EN is defined)
//   o_busy       : receiver is inside a frame
// Modports: slave = receiver side, master = line/baud driver and consumer side.
// Optional feature macro: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int NB_BITS = 8
);

  logic               i_rate;
  logic               i_rx;
  logic [NB_BITS-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;
  logic               o_busy;
`ifdef UART_RX_PARITY_EN
  logic               o_parity_err;

  modport slave (
    input  i_rate, i_rx,
    output o_data, o_rx_done, o_frame_err, o_parity_err, o_busy
  );

  modport master (
    output i_rate, i_rx,
    input  o_data, o_rx_done, o_frame_err, o_parity_err, o_busy
  );
`else
  modport slave (
    input  i_rate, i_rx,
    output o_data, o_rx_done, o_frame_err, o_busy
  );

  modport master (
    output i_rate, i_rx,
    input  o_data, o_rx_done, o_frame_err, o_busy
  );
`endif

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous inputs.
//   i_clk     : destination clock
//   i_rst_n   : asynchronous active-low reset
//   i_d       : asynchronous input
//   o_q       : synchronised output, two cycles of latency
// RESET_VAL sets the value both flops take in reset, so an input that idles
// at a non-zero level does not produce a spurious edge when reset releases.
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 16x (OVERSAMPLE) oversampled, start bit, NB_BITS data bits
// LSB first, optional parity bit, one stop bit.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : uart_rx_if.slave (i_rate, i_rx, o_data, o_rx_done,
//             o_frame_err, [o_parity_err], o_busy)
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY_ODD parameter,
// the PARITY state and the o_parity_err strobe.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_BITS    = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic     i_clk,
  input logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int TickW   = clog2(OVERSAMPLE);
  localparam int BitW    = clog2(NB_BITS + 1);
  localparam int MidTick = mid_tick(OVERSAMPLE);

  uart_state_e        state_q, state_d;
  logic [TickW-1:0]   tickCnt_q, tickCnt_d;
  logic [BitW-1:0]    bitCnt_q, bitCnt_d;
  logic [NB_BITS-1:0] shiftReg_q, shiftReg_d;
  logic [NB_BITS-1:0] data_q, data_d;
  logic               rxDone_q, rxDone_d;
  logic               frameErr_q, frameErr_d;
`ifdef UART_RX_PARITY_EN
  logic               parityBit_q, parityBit_d;
  logic               parityErr_q, parityErr_d;
`endif
  logic               rxSync;
  logic               midTick;
  logic               endTick;
  logic               lastBit;

  // The line idles high, so the synchroniser resets to 1 to avoid reading a
  // start bit the moment reset is released.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_rx),
    .o_q     (rxSync)
  );

  assign midTick = bus.i_rate && (tickCnt_q == TickW'(MidTick));
  assign endTick = bus.i_rate && (tickCnt_q == TickW'(OVERSAMPLE - 1));
  assign lastBit = (bitCnt_q == BitW'(NB_BITS - 1));

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      tickCnt_q   <= '0;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      data_q      <= '0;
      rxDone_q    <= 1'b0;
      frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      bitCnt_q    <= bitCnt_d;
      shiftReg_q  <= shiftReg_d;
      data_q      <= data_d;
      rxDone_q    <= rxDone_d;
      frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= parityBit_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  // Frame sequencing. START re-checks the line at mid start bit so a short
  // glitch falls back to IDLE. STOP leaves at mid stop bit, which leaves half a
  // bit of slack to catch a start bit that follows with no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxSync) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (midTick) begin
          state_d = rxSync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (endTick && lastBit) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (endTick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (endTick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and strobes. The tick counter restarts on every state change and
  // otherwise wraps naturally, so each DATA sample lands one bit period after
  // the previous one. The shift register is never cleared because every frame
  // overwrites all of its bits before it is copied to o_data.
  always_comb begin
    tickCnt_d   = tickCnt_q;
    bitCnt_d    = bitCnt_q;
    shiftReg_d  = shiftReg_q;
    data_d      = data_q;
    rxDone_d    = 1'b0;
    frameErr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBit_d = parityBit_q;
    parityErr_d = 1'b0;
`endif

    if (state_d != state_q) begin
      tickCnt_d = '0;
    end else if (bus.i_rate && (state_q != ST_IDLE)) begin
      tickCnt_d = tickCnt_q + TickW'(1);
    end

    if ((state_q == ST_START) && (state_d == ST_DATA)) begin
      bitCnt_d = '0;
    end

    if ((state_q == ST_DATA) && endTick) begin
      shiftReg_d = {rxSync, shiftReg_q[NB_BITS-1:1]};
      bitCnt_d   = bitCnt_q + BitW'(1);
    end

`ifdef UART_RX_PARITY_EN
    if ((state_q == ST_PARITY) && endTick) begin
      parityBit_d = rxSync;
    end
`endif

    if ((state_q == ST_STOP) && endTick) begin
      data_d     = shiftReg_q;
      rxDone_d   = 1'b1;
      frameErr_d = ~rxSync;
`ifdef UART_RX_PARITY_EN
      parityErr_d = ((^shiftReg_q) ^ parityBit_q) != PARITY_ODD;
`endif
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_rx_done    = rxDone_q;
  assign bus.o_frame_err  = frameErr_q;
  assign bus.o_busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = parityErr_q;
`endif

endmodule
